// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: M-extension funct3 codes,
// FSM state encodings and operand-signedness helpers.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic op_a_signed(input logic [2:0] op);
    return !(op == OP_MULHU || op == OP_DIVU || op == OP_REMU);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MUL || op == OP_MULH || op == OP_DIV || op == OP_REM);
  endfunction

  function automatic logic op_hi_half(input logic [2:0] op);
    return (op == OP_MULH || op == OP_MULHSU || op == OP_MULHU);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative engine: one shift-add (multiply) or restoring shift-subtract
// (divide) step per cycle on a 2*XLEN accumulator, XLEN steps per operation.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   a_mag_i,
  input  logic [XLEN-1:0]   b_mag_i,
  output logic              done_o,
  output logic [2*XLEN-1:0] acc_o
);
  localparam int CW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc_q, acc_d, mul_step, div_step;
  logic [XLEN-1:0]   b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              run_q, run_d, div_q, div_d;
  logic [XLEN:0]     sum, rem_sh, diff;

  // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
  assign sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
  assign mul_step = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

  // Divide: a borrow out of the trial subtraction means the quotient bit is 0.
  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign diff     = rem_sh - {1'b0, b_q};
  assign div_step = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  assign done_o = run_q & (cnt_q == '0);
  assign acc_o  = acc_q;

  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    run_d = run_q;
    div_d = div_q;
    if (clear_i) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start_i) begin
      acc_d = {{XLEN{1'b0}}, a_mag_i};
      b_d   = b_mag_i;
      div_d = is_div_i;
      cnt_d = CW'(XLEN - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = div_q ? div_step : mul_step;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        run_d = 1'b0;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes and flush.
// Define MULDIV_FAST_MUL_EN to form multiplies in one cycle in FIX instead of iterating.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d, out_tag_q, out_tag_d;
  logic              neg_q, neg_d, div0_q, div0_d, ovf_q, ovf_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d, res_q, res_d;

  logic              accept, a_neg, b_neg, b_zero, ovf_in, special_in, fast_in, neg_in;
  logic              core_start, core_done;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic [2*XLEN-1:0] acc, prod, mag, fixed;

`ifdef MULDIV_FAST_MUL_EN
  logic [XLEN-1:0] b_mag_q, b_mag_d;
  assign b_mag_d = (state_q == MD_IDLE && accept) ? b_mag_in : b_mag_q;
  always_ff @(posedge clk) begin
    if (rst) b_mag_q <= '0;
    else     b_mag_q <= b_mag_d;
  end
  assign fast_in = ~in_op[2];
  assign prod    = {{XLEN{1'b0}}, a_mag_q} * {{XLEN{1'b0}}, b_mag_q};
`else
  assign fast_in = 1'b0;
  assign prod    = acc;
`endif

  assign in_ready   = (state_q == MD_IDLE);
  assign busy       = ~in_ready;
  assign out_valid  = (state_q == MD_DONE);
  assign out_result = res_q;
  assign out_tag    = out_tag_q;

  assign accept     = in_valid & in_ready;
  assign a_neg      = in_a[XLEN-1] & op_a_signed(in_op);
  assign b_neg      = in_b[XLEN-1] & op_b_signed(in_op);
  assign a_mag_in   = a_neg ? -in_a : in_a;
  assign b_mag_in   = b_neg ? -in_b : in_b;
  assign b_zero     = (in_b == '0);
  assign ovf_in     = (in_op == OP_DIV || in_op == OP_REM) && (in_a == MIN_NEG) && (in_b == '1);
  assign special_in = in_op[2] & (b_zero | ovf_in);
  assign core_start = accept & ~special_in & ~fast_in & ~flush;
  // Remainders follow the dividend; quotients/products follow the operand-sign XOR.
  assign neg_in     = in_op[2] ? (in_op[1] ? a_neg : (~b_zero & (a_neg ^ b_neg)))
                               : (a_neg ^ b_neg);

  muldiv_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (flush),
    .start_i  (core_start),
    .is_div_i (in_op[2]),
    .a_mag_i  (a_mag_in),
    .b_mag_i  (b_mag_in),
    .done_o   (core_done),
    .acc_o    (acc)
  );

  always_comb begin
    mag = prod;
    if (div0_q)
      mag = op_q[1] ? {{XLEN{1'b0}}, a_mag_q} : {{XLEN{1'b0}}, {XLEN{1'b1}}};
    else if (ovf_q)
      mag = op_q[1] ? '0 : {{XLEN{1'b0}}, a_mag_q};
    else if (op_q[2])
      mag = op_q[1] ? {{XLEN{1'b0}}, acc[2*XLEN-1:XLEN]} : {{XLEN{1'b0}}, acc[XLEN-1:0]};
  end

  assign fixed = neg_q ? -mag : mag;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    neg_d     = neg_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    a_mag_d   = a_mag_q;
    res_d     = res_q;
    out_tag_d = out_tag_q;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          op_d    = in_op;
          tag_d   = in_tag;
          neg_d   = neg_in;
          div0_d  = in_op[2] & b_zero;
          ovf_d   = ovf_in;
          a_mag_d = a_mag_in;
          state_d = (special_in | fast_in) ? MD_FIX : MD_CALC;
        end
      end
      MD_CALC: if (core_done) state_d = MD_FIX;
      MD_FIX: begin
        res_d     = op_hi_half(op_q) ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];
        out_tag_d = tag_q;
        state_d   = MD_DONE;
      end
      MD_DONE: if (out_ready) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (flush) state_d = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      op_q      <= '0;
      tag_q     <= '0;
      neg_q     <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      a_mag_q   <= '0;
      res_q     <= '0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      neg_q     <= neg_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      a_mag_q   <= a_mag_d;
      res_q     <= res_d;
      out_tag_q <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed cases, then random ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Reference model: RISC-V M semantics via 64-bit integer arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub;
        return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        q = sa % sb;
        return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return MUL_LAT;
    if (b == 0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
    return 34;
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge after the result is taken.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp_res, input int exp_lat,
                        input int hold, input string name);
    int lat;
    bit seen;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    if (!seen) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      return;
    end
    chk({name, "_res"}, 64'(out_result), 64'(exp_res));
    chk({name, "_tag"}, 64'(out_tag), 64'(tag));
    $display("txn %s op=%0d a=%h b=%h result=%h tag=%0d latency=%0d", name, op, a, b, out_result, out_tag, lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold"}, 64'({out_valid, in_ready, out_result, out_tag}), 64'({1'b1, 1'b0, exp_res, tag}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({name, "_post"}, 64'({in_ready, out_valid, busy}), 64'({1'b1, 1'b0, 1'b0}));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    bit          saw;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", 64'({busy, in_ready, out_valid, out_result, out_tag}), 64'({1'b0, 1'b1, 1'b0, 32'h0, 5'h0}));
    rst = 1'b0;

    // Multiplies
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, MUL_LAT, 0, "mul");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, MUL_LAT, 0, "mulhu");
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h00000000, MUL_LAT, 0, "mulh");
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, MUL_LAT, 0, "mulhsu");

    // Divides
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 34, 0, "div");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 34, 0, "rem");
    run_op(3'd5, 32'd20, 32'd3, 5'd7, 32'd6, 34, 0, "divu");
    run_op(3'd7, 32'd20, 32'd3, 5'd8, 32'd2, 34, 0, "remu");

    // Special cases
    run_op(3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF, 2, 0, "divu_by0");
    run_op(3'd4, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, 2, 0, "div_by0");
    run_op(3'd6, 32'd5, 32'd0, 5'd11, 32'd5, 2, 0, "rem_by0");
    run_op(3'd7, 32'hFFFFFFFB, 32'd0, 5'd12, 32'hFFFFFFFB, 2, 0, "remu_by0");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 2, 0, "div_ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, 2, 0, "rem_ovf");

    // Back-pressure in DONE
    run_op(3'd4, 32'd100, 32'hFFFFFFF9, 5'd21, 32'hFFFFFFF2, 34, 5, "hold_div");

    // Flush at cycle 10 of a divide
    in_valid = 1'b1; in_op = 3'd4; in_a = 32'd1000; in_b = 32'd7; in_tag = 5'd22;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("flush_busy_c10", 64'(busy), 64'(1));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_c11", 64'({busy, in_ready, out_valid}), 64'({1'b0, 1'b1, 1'b0}));
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("flush_noval", 64'(saw), 64'(0));
    $display("txn flush_div tag=22 squashed at cycle 10");
    run_op(3'd5, 32'd1000, 32'd7, 5'd23, 32'd142, 34, 0, "after_flush");

    // Reset at cycle 10 of a divide
    in_valid = 1'b1; in_op = 3'd6; in_a = 32'd1000; in_b = 32'd7; in_tag = 5'd24;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_c11", 64'({busy, in_ready, out_valid, out_result, out_tag}), 64'({1'b0, 1'b1, 1'b0, 32'h0, 5'h0}));
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("rst_noval", 64'(saw), 64'(0));
    $display("txn rst_rem tag=24 squashed at cycle 10");

    // Random operations against the reference model
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       ra = 32'h80000000;
        1:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 5'($urandom_range(0, 31)), ref_md(rop, ra, rb), ref_lat(rop, ra, rb),
             $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
